// File: rtl/add_sub_scheduler_if.sv
// add_sub_scheduler_if: two request channels and one tagged response channel
interface add_sub_scheduler_if #(parameter int WIDTH = 32);
    logic             in0_valid, in0_ready, in0_sub;
    logic [WIDTH-1:0] in0_a, in0_b;
    logic             in1_valid, in1_ready, in1_sub;
    logic [WIDTH-1:0] in1_a, in1_b;
    logic             out_valid, out_ready, out_id;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in0_valid, in0_a, in0_b, in0_sub,
        output in1_valid, in1_a, in1_b, in1_sub,
        output out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  in0_valid, in0_a, in0_b, in0_sub,
        input  in1_valid, in1_a, in1_b, in1_sub,
        input  out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/add_sub_scheduler.sv
// add_sub_scheduler: round-robin time-sharing of one 32-bit CLA for add/sub requests
module add_sub_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] g, p, c;
    logic [7:0]  bg, bp, bc;
    logic        carry;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar i = 0; i < 8; i++) begin : grp
        localparam int j = 4 * i;
        assign bg[i]  = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
                      | (p[j+3] & p[j+2] & p[j+1] & g[j]);
        assign bp[i]  = &p[j+:4];
        assign c[j]   = bc[i];
        assign c[j+1] = g[j] | (p[j] & bc[i]);
        assign c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & bc[i]);
        assign c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
                      | (p[j+2] & p[j+1] & p[j] & bc[i]);
    end

    // group carry chain: carry-in tied to 0, final carry-out discarded
    always_comb begin
        carry = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bc[i] = carry;
            carry = bg[i] | (bp[i] & carry);
        end
    end

    assign sum = p ^ c;
endmodule

module add_sub_scheduler #(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    add_sub_scheduler_if.slave   bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, acc, add_a, add_b, sum;
    logic             sub_q, id_q, last_ptr, out_valid_q, grant0, grant1;

    // round-robin grant: on a tie the requester not served last wins
    always_comb begin
        grant1 = bus.in1_valid && (!bus.in0_valid || !last_ptr);
        grant0 = bus.in0_valid && !grant1;
    end

    // adder operands per pass; held at zero when the adder is idle
    always_comb begin
        add_a = state == PASS1 ? a_q : state == PASS2 ? acc : '0;
        add_b = state == PASS1 ? (sub_q ? ~b_q : b_q) : state == PASS2 ? WIDTH'(1) : '0;
    end

    add_sub_cla32 u_cla (.a(add_a), .b(add_b), .sum(sum));

    assign bus.in0_ready = (state == IDLE) && grant0;
    assign bus.in1_ready = (state == IDLE) && grant1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.out_id    = id_q;
    assign busy          = state != IDLE;

    // accept, run one or two adder passes, then hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            sub_q       <= 1'b0;
            id_q        <= 1'b0;
            last_ptr    <= RR_INIT;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    a_q      <= grant1 ? bus.in1_a : bus.in0_a;
                    b_q      <= grant1 ? bus.in1_b : bus.in0_b;
                    sub_q    <= grant1 ? bus.in1_sub : bus.in0_sub;
                    id_q     <= grant1;
                    last_ptr <= grant1;
                    state    <= PASS1;
                end
                PASS1: begin
                    acc         <= sum;
                    state       <= sub_q ? PASS2 : DONE;
                    out_valid_q <= !sub_q;
                end
                PASS2: begin
                    acc         <= sum;
                    state       <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_sub_scheduler.sv
// tb_add_sub_scheduler: directed checks of add/sub scheduling, arbitration, backpressure and reset
module tb_add_sub_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    add_sub_scheduler_if #(.WIDTH(32)) bus ();

    add_sub_scheduler #(.WIDTH(32), .RR_INIT(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        if (id) begin
            bus.in1_valid = v; bus.in1_a = a; bus.in1_b = b; bus.in1_sub = s;
        end else begin
            bus.in0_valid = v; bus.in0_a = a; bus.in0_b = b; bus.in0_sub = s;
        end
    endtask

    task automatic wait_result(input logic sub, input logic id, input logic [31:0] exp);
        int lat = 0;
        while (!bus.out_valid && lat < 8) begin
            tick();
            lat++;
        end
        check("latency", lat, sub ? 2 : 1);
        check("out_data", bus.out_data, exp);
        check("out_id", 32'(bus.out_id), 32'(id));
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] exp);
        set_req(id, 1'b1, a, b, sub);
        #1;
        check("ready_sel", 32'(id ? bus.in1_ready : bus.in0_ready), 1);
        check("ready_other", 32'(id ? bus.in0_ready : bus.in1_ready), 0);
        tick();
        set_req(id, 1'b0, 32'hdead_beef, 32'h1234_5678, ~sub);
        check("ready_after_accept", 32'(bus.in0_ready | bus.in1_ready), 0);
        check("busy_in_pass1", 32'(busy), 1);
        wait_result(sub, id, exp);
        tick();
        check("valid_pulse", 32'(bus.out_valid), 0);
    endtask

    initial begin
        int n;
        int seen;
        logic        ids [4];
        logic [31:0] dat [4];
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_id", 32'(bus.out_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(bus.in0_ready | bus.in1_ready), 0);
        rst = 1'b0;
        tick();

        run_op(1'b0, 32'd5, 32'd7, 1'b0, 32'd12);
        run_op(1'b1, 32'd10, 32'd3, 1'b1, 32'd7);
        run_op(1'b1, 32'd3, 32'd10, 1'b1, 32'hFFFF_FFF9);
        run_op(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        run_op(1'b1, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0);
        run_op(1'b0, 32'd2, 32'd3, 1'b0, 32'd5);

        bus.out_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'd100, 32'd1, 1'b1);
        tick();
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        wait_result(1'b1, 1'b0, 32'd99);
        set_req(1'b0, 1'b1, 32'd20, 32'd22, 1'b0);
        set_req(1'b1, 1'b1, 32'd9, 32'd4, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_data", bus.out_data, 32'd99);
            check("hold_id", 32'(bus.out_id), 0);
            check("hold_busy", 32'(busy), 1);
            check("hold_ready", 32'(bus.in0_ready | bus.in1_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.out_valid), 0);
        check("bp_release_busy", 32'(busy), 0);
        check("bp_grant_in1", 32'(bus.in1_ready), 1);
        check("bp_grant_in0", 32'(bus.in0_ready), 0);
        tick();
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        check("bp_next_busy", 32'(busy), 1);
        wait_result(1'b1, 1'b1, 32'd5);
        tick();
        check("bp_next_pulse", 32'(bus.out_valid), 0);

        run_op(1'b0, 32'd1, 32'd2, 1'b0, 32'd3);
        set_req(1'b0, 1'b1, 32'd50, 32'd8, 1'b1);
        tick();
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        check("pass2_busy", 32'(busy), 1);
        check("pass2_valid", 32'(bus.out_valid), 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_data", bus.out_data, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("no_resp_after_rst", seen, 0);

        set_req(1'b0, 1'b1, 32'd1, 32'd1, 1'b0);
        set_req(1'b1, 1'b1, 32'd4, 32'd1, 1'b1);
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (bus.out_valid) begin
                ids[n] = bus.out_id;
                dat[n] = bus.out_data;
                n++;
            end
        end
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        check("rr_count", n, 4);
        for (int k = 0; k < n; k++) begin
            check("rr_id", 32'(ids[k]), k % 2);
            check("rr_data", dat[k], (k % 2 == 1) ? 32'd3 : 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
